// File: rtl/mdsa_stream_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdsa_stream_buffer: stream-in / matrix-out front end and sorted-matrix
// stream-out back end for the bitonic MDSA sorter.      Rev 1.0
// ---------------------------------------------------------------------------
module mdsa_stream_buffer #(
  parameter int DATA_W  = 8,
  parameter int DIM     = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  input  logic                      fsm_ready,
  input  logic                      fsm_output_enable,
  output logic                      start,
  output logic [DIM*DIM*DATA_W-1:0] mat_out,
  input  logic [DIM*DIM*DATA_W-1:0] sorted_in,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      err
);
  localparam int N      = DIM * DIM;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {LOAD, ARM, SORT, UNLOAD} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    wr_idx, rd_idx;
  logic [TCNT_W-1:0]   tcnt;
  logic [DATA_W-1:0]   out_mem [N];
  logic                accept, emit, capture, timeout_hit;

  assign in_ready    = (state == LOAD) && !rst;
  assign out_valid   = (state == UNLOAD);
  assign out_data    = out_mem[rd_idx];
  assign out_last    = out_valid && (rd_idx == LAST_IDX);
  assign busy        = (state != LOAD);
  assign accept      = in_valid && in_ready;
  assign emit        = out_valid && out_ready;
  assign capture     = (state == SORT) && fsm_output_enable;
  // tcnt counts completed SORT cycles; abort on the TIMEOUT-th one
  assign timeout_hit = (state == SORT) && !fsm_output_enable && (tcnt == TCNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && wr_idx == LAST_IDX) state_nxt = ARM;
      ARM:     if (fsm_ready) state_nxt = SORT;
      SORT: begin
        if (capture)          state_nxt = UNLOAD;
        else if (timeout_hit) state_nxt = LOAD;
      end
      UNLOAD:  if (emit && rd_idx == LAST_IDX) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx  <= '0;
      rd_idx  <= '0;
      tcnt    <= '0;
      start   <= 1'b0;
      err     <= 1'b0;
      mat_out <= '0;
      for (int k = 0; k < N; k++) out_mem[k] <= '0;
    end else begin
      start <= (state == ARM) && fsm_ready;
      tcnt  <= (state == SORT && !capture && !timeout_hit) ? tcnt + 1'b1 : '0;
      if (accept) begin
        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
        for (int k = 0; k < N; k++)
          if (wr_idx == IDX_W'(k)) mat_out[k*DATA_W +: DATA_W] <= in_data;
      end
      if (timeout_hit) begin
        err    <= 1'b1;
        wr_idx <= '0;
      end
      if (capture)
        for (int k = 0; k < N; k++) out_mem[k] <= sorted_in[k*DATA_W +: DATA_W];
      if (emit) rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: doc/mdsa_stream_buffer.md
Name: mdsa_stream_buffer

Overview:
- Streaming front/back end for the bitonic MDSA sorter.
- Collects DIM*DIM words from an upstream valid/ready stream into a matrix register, presents it to the sort datapath, and issues a one-cycle START to the sort controller once the controller reports READY.
- Captures the sorted matrix on the controller's output_enable pulse, then streams it out in row-major order.
- Sits directly between the external data stream and the MDSA controller/datapath pair.

Parameters:
- DATA_W, 8, element width in bits
- DIM, 4, matrix dimension; DIM*DIM elements per sort
- TIMEOUT, 255, maximum SORT-state cycles before abort; must be >= 1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream element valid
- in_data  in  DATA_W  upstream element
- in_ready  out  1  buffer accepts element
- fsm_ready  in  1  controller READY
- fsm_output_enable  in  1  controller output_enable pulse; sorted result is valid on sorted_in in this cycle
- start  out  1  START to controller, one-cycle pulse
- mat_out  out  DIM*DIM*DATA_W  loaded matrix to datapath; element k at bits [k*DATA_W +: DATA_W], row-major
- sorted_in  in  DIM*DIM*DATA_W  sorted matrix from datapath, same packing
- out_valid  out  1  output element valid
- out_data  out  DATA_W  output element
- out_last  out  1  marks element DIM*DIM-1
- out_ready  in  1  downstream accepts element
- busy  out  1  high in ARM, SORT or UNLOAD
- err  out  1  sticky timeout flag

Behaviour:
- Reset (asynchronous, active-high):
  - state=LOAD; wr_idx=0, rd_idx=0, tcnt=0.
  - mat_out=0, out buffer=0, start=0, err=0.
  - in_ready forced 0 while rst is high.
- States: LOAD, ARM, SORT, UNLOAD. All transitions occur on rising clk.
- LOAD:
  - in_ready=1 (combinational from state, gated by !rst).
  - Each in_valid&in_ready handshake writes in_data to element wr_idx; wr_idx increments.
  - The accept at wr_idx==DIM*DIM-1 sets wr_idx=0 and moves to ARM.
  - Elements not yet written keep their previous contents.
- ARM:
  - in_ready=0.
  - When fsm_ready=1: start registers 1 and state moves to SORT, so start is high for exactly the first SORT cycle.
  - While fsm_ready=0: stay in ARM, start=0.
- SORT:
  - mat_out held stable; tcnt increments every cycle.
  - When fsm_output_enable=1: capture sorted_in into the out buffer, tcnt=0, go to UNLOAD.
  - When tcnt reaches TIMEOUT with no fsm_output_enable: set err=1, tcnt=0, go to LOAD, discard the matrix (wr_idx=0).
  - If fsm_output_enable and the timeout coincide, the capture wins and err is not set.
- UNLOAD:
  - out_valid=1; out_data=out buffer element rd_idx; out_last=(rd_idx==DIM*DIM-1).
  - out_data and out_last stay stable while out_valid&!out_ready.
  - Each out_valid&out_ready handshake increments rd_idx.
  - Handshake on the last element sets rd_idx=0 and goes to LOAD.
  - in_ready is first 1 in the cycle after the last handshake.
- Outside UNLOAD: out_valid=0, out_last=0.
- fsm_output_enable is ignored outside SORT.
- start is never asserted outside the ARM->SORT transition.
- busy = (state != LOAD).
- err clears only on rst.
- Index counters are $clog2(DIM*DIM) bits wide; they never wrap except at the defined terminal counts above.
- Reset mid-operation: all state is lost, including a partial load, a pending sort or a partial unload. No start or out_valid glitch occurs after reset release.
- Throughput: one element per cycle in LOAD and in UNLOAD with no backpressure.

Test Plan:
- Reset then stream elements 16..1 with in_valid held high -> in_ready high for 16 cycles, then low; mat_out element0=16, element15=1; start pulses one cycle when fsm_ready=1.
- ARM with fsm_ready held 0 for 5 cycles, then 1 -> start stays 0 for 5 cycles, then exactly one pulse; busy=1 throughout.
- In SORT, drive sorted_in=1..16 and pulse fsm_output_enable -> out_data 1,2,...,16 on consecutive cycles with out_ready=1; out_last only on 16; in_ready=1 the next cycle.
- Toggle out_ready 1,0,0,1,... during UNLOAD -> out_data/out_last hold during stalls; every element is emitted exactly once, in order.
- With TIMEOUT=10, never pulse fsm_output_enable -> after 10 SORT cycles err=1 and state returns to LOAD with in_ready=1; a late fsm_output_enable pulse is ignored (out_valid stays 0).
- Assert rst after the 7th accepted element -> in_ready=0 during reset; after release the next 16 accepts complete a full load; start is not pulsed early.
